item_selector: RTL and testbench
================================

ITEM_SELECTOR -- requirements
Module: item_selector

Interface
REQ-001 The block SHALL have parameter NUM_ITEMS, default 8: number of selectable items, range 2..16.
REQ-002 The block SHALL have parameter CREDIT_W, default 8: width of the credit, price and change values.
REQ-003 The block SHALL have parameter HOLD_CYCLES, default 16: duration in cycles of the DISPENSE and DENY states, minimum 1.
REQ-004 fastClk  in  1  sole clock; all state updates on its rising edge.
REQ-005 rstN  in  1  reset; asynchronous and active-low.
REQ-006 rightSignal  in  1  single-cycle debounced pulse; move cursor up.
REQ-007 leftSignal  in  1  single-cycle debounced pulse; move cursor down.
REQ-008 selectSignal  in  1  debounced level; a 0->1 transition requests purchase of the cursor item.
REQ-009 coinPulse  in  1  single-cycle pulse; a coin of value coinValue is inserted.
REQ-010 coinValue  in  CREDIT_W  value of the inserted coin; sampled only when coinPulse=1.
REQ-011 itemPrice  in  CREDIT_W  price of the item at cursor; supplied combinationally by an external table.
REQ-012 cursor  out  4  currently highlighted item, range 0..NUM_ITEMS-1.
REQ-013 credit  out  CREDIT_W  accumulated credit.
REQ-014 dispense  out  1  single-cycle pulse on entry to DISPENSE.
REQ-015 dispenseItem  out  4  item index latched at the purchase request.
REQ-016 change  out  CREDIT_W  credit minus price, valid while dispense=1 or busy=1.
REQ-017 busy  out  1  high in CHECK, DISPENSE and DENY.
REQ-018 deny  out  1  high throughout DENY.

Function
REQ-019 The FSM SHALL have the states IDLE, CHECK, DISPENSE and DENY.
REQ-020 In IDLE, rightSignal alone SHALL increment cursor, leftSignal alone SHALL decrement it, and both together SHALL leave it unchanged.
REQ-021 At the upper and lower cursor bounds, behaviour SHALL be as defined by REQ-033/REQ-034.
REQ-022 Cursor moves SHALL be ignored while busy=1.
REQ-023 The block SHALL register selectSignal and detect its rising edge internally; a rising edge in IDLE SHALL latch cursor into dispenseItem and itemPrice into an internal price register, and move the FSM to CHECK on the next edge.
REQ-024 CHECK SHALL last exactly 1 cycle, then go to DISPENSE if credit >= latched price, else to DENY.
REQ-025 On entry to DISPENSE: dispense=1 for exactly 1 cycle, change = credit - price, and credit SHALL be cleared to 0 in the same cycle.
REQ-026 DISPENSE and DENY SHALL each last HOLD_CYCLES cycles, counted by an internal counter, then return to IDLE; credit SHALL be unchanged by DENY.
REQ-027 Coins SHALL be accepted in every state, credit = min(credit + coinValue, 2^CREDIT_W - 1) (saturating).
REQ-028 A coin arriving in the DISPENSE entry cycle SHALL be added after the clear, so that credit = coinValue.
REQ-029 Select edges arriving while busy=1 SHALL be discarded, not queued.
REQ-030 Purchase latency SHALL be 2 cycles: select edge registered -> CHECK -> dispense pulse.

Reset
REQ-031 On rstN=0 the block SHALL immediately force: state IDLE, cursor 0, credit 0, dispense 0, dispenseItem 0, change 0, busy 0, deny 0, hold counter 0, select history 0.
REQ-032 A reset asserted mid-DISPENSE or mid-DENY SHALL abort the hold with no further dispense pulse, and credit SHALL be lost.

Configuration
REQ-033 With ITEM_SELECTOR_WRAP_EN defined, cursor SHALL wrap from NUM_ITEMS-1 to 0 on right and from 0 to NUM_ITEMS-1 on left.
REQ-034 Without ITEM_SELECTOR_WRAP_EN defined, cursor SHALL saturate at 0 and at NUM_ITEMS-1.

Verification
REQ-035 Reset, then 3 right pulses and 1 left pulse -> cursor=2; left and right in the same cycle -> cursor stays 2.
REQ-036 At cursor=7 (NUM_ITEMS=8), one right pulse -> cursor=0 with the macro defined, cursor=7 without it.
REQ-037 Coins of 25, 25, 10 with itemPrice=50, then a select edge -> dispense pulse 2 cycles after the edge, change=10, credit=0, dispenseItem=cursor.
REQ-038 credit=30 with itemPrice=50, then a select edge -> deny=1 for 16 cycles, credit stays 30, no dispense pulse.
REQ-039 credit=250 plus a coin of 10 -> credit=255; a select edge during DENY is ignored and the FSM returns to IDLE after the hold.
REQ-040 rstN asserted in the 5th cycle of DISPENSE -> all outputs 0 at once, then IDLE after release.

Source files
------------

// File: rtl/item_selector.sv
// item_selector: cursor-driven item selection with coin credit, purchase check,
// and timed dispense/deny hold.
//
// Ports:
//   fastClk       sole clock, rising edge
//   rstN          asynchronous active-low reset
//   rightSignal   pulse, move cursor up (IDLE only)
//   leftSignal    pulse, move cursor down (IDLE only)
//   selectSignal  debounced level, rising edge requests purchase of cursor item
//   coinPulse     pulse, adds coinValue to credit (saturating), any state
//   coinValue     coin value, sampled with coinPulse
//   itemPrice     price of the cursor item from an external table
//   cursor        highlighted item
//   credit        accumulated credit
//   dispense      one-cycle pulse on DISPENSE entry
//   dispenseItem  item index latched at the purchase request
//   change        credit minus price, set on DISPENSE entry
//   busy          high in CHECK, DISPENSE and DENY
//   deny          high throughout DENY
//
// Configuration macro: ITEM_SELECTOR_WRAP_EN -- when defined the cursor wraps
// at both ends, otherwise it saturates at 0 and NUM_ITEMS-1.

module item_selector #(
    parameter int unsigned NUM_ITEMS   = 8,
    parameter int unsigned CREDIT_W    = 8,
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic                fastClk,
    input  logic                rstN,
    input  logic                rightSignal,
    input  logic                leftSignal,
    input  logic                selectSignal,
    input  logic                coinPulse,
    input  logic [CREDIT_W-1:0] coinValue,
    input  logic [CREDIT_W-1:0] itemPrice,
    output logic [3:0]          cursor,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic [3:0]          dispenseItem,
    output logic [CREDIT_W-1:0] change,
    output logic                busy,
    output logic                deny
);

    localparam int unsigned HOLD_W    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] LAST_HOLD = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [3:0]        LAST_IDX  = 4'(NUM_ITEMS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CHECK,
        ST_DISPENSE,
        ST_DENY
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          cursor_q, cursor_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic                dispense_q, dispense_d;
    logic [3:0]          item_q, item_d;
    logic [CREDIT_W-1:0] change_q, change_d;
    logic                busy_q, busy_d;
    logic                deny_q, deny_d;
    logic [HOLD_W-1:0]   hold_q, hold_d;
    logic                sel_q, sel_d;
    logic [CREDIT_W-1:0] price_q, price_d;

    logic                sel_rise;
    logic [CREDIT_W-1:0] credit_base;
    logic [CREDIT_W-1:0] coin_add;
    logic [CREDIT_W:0]   credit_sum;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        dispense_d  = 1'b0;
        item_d      = item_q;
        change_d    = change_q;
        hold_d      = hold_q;
        price_d     = price_q;
        sel_d       = selectSignal;
        sel_rise    = selectSignal & ~sel_q;
        credit_base = credit_q;
        coin_add    = coinPulse ? coinValue : '0;

        unique case (state_q)
            ST_IDLE: begin
                if (rightSignal && !leftSignal) begin
                    if (cursor_q == LAST_IDX) begin
`ifdef ITEM_SELECTOR_WRAP_EN
                        cursor_d = 4'd0;
`else
                        cursor_d = LAST_IDX;
`endif
                    end else begin
                        cursor_d = cursor_q + 4'd1;
                    end
                end else if (leftSignal && !rightSignal) begin
                    if (cursor_q == 4'd0) begin
`ifdef ITEM_SELECTOR_WRAP_EN
                        cursor_d = LAST_IDX;
`else
                        cursor_d = 4'd0;
`endif
                    end else begin
                        cursor_d = cursor_q - 4'd1;
                    end
                end
                if (sel_rise) begin
                    item_d  = cursor_q;
                    price_d = itemPrice;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                hold_d = '0;
                if (credit_q >= price_q) begin
                    state_d     = ST_DISPENSE;
                    dispense_d  = 1'b1;
                    change_d    = credit_q - price_q;
                    // Credit is consumed; a coin in this cycle lands on zero
                    credit_base = '0;
                end else begin
                    state_d = ST_DENY;
                end
            end
            ST_DISPENSE, ST_DENY: begin
                if (hold_q == LAST_HOLD) begin
                    state_d = ST_IDLE;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
        endcase

        // Saturating credit accumulation
        credit_sum = {1'b0, credit_base} + {1'b0, coin_add};
        credit_d   = credit_sum[CREDIT_W] ? '1 : credit_sum[CREDIT_W-1:0];

        busy_d = (state_d != ST_IDLE);
        deny_d = (state_d == ST_DENY);
    end

    // State and output registers
    always_ff @(posedge fastClk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= ST_IDLE;
            cursor_q   <= '0;
            credit_q   <= '0;
            dispense_q <= 1'b0;
            item_q     <= '0;
            change_q   <= '0;
            busy_q     <= 1'b0;
            deny_q     <= 1'b0;
            hold_q     <= '0;
            sel_q      <= 1'b0;
            price_q    <= '0;
        end else begin
            state_q    <= state_d;
            cursor_q   <= cursor_d;
            credit_q   <= credit_d;
            dispense_q <= dispense_d;
            item_q     <= item_d;
            change_q   <= change_d;
            busy_q     <= busy_d;
            deny_q     <= deny_d;
            hold_q     <= hold_d;
            sel_q      <= sel_d;
            price_q    <= price_d;
        end
    end

    assign cursor       = cursor_q;
    assign credit       = credit_q;
    assign dispense     = dispense_q;
    assign dispenseItem = item_q;
    assign change       = change_q;
    assign busy         = busy_q;
    assign deny         = deny_q;

endmodule

// File: tb/tb_item_selector.sv
// Testbench for item_selector (default parameters): cursor vector table,
// directed purchase/deny/saturation/reset sequences, and random stimulus
// checked against a behavioural model.

module tb_item_selector;

    localparam int N     = 8;
    localparam int HOLD  = 16;
    localparam int MAXC  = 255;
`ifdef ITEM_SELECTOR_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       fastClk = 1'b0;
    logic       rstN;
    logic       rightSignal, leftSignal, selectSignal, coinPulse;
    logic [7:0] coinValue, itemPrice;
    logic [3:0] cursor, dispenseItem;
    logic [7:0] credit, change;
    logic       dispense, busy, deny;

    item_selector #(.NUM_ITEMS(N), .CREDIT_W(8), .HOLD_CYCLES(HOLD)) dut (
        .fastClk      (fastClk),
        .rstN         (rstN),
        .rightSignal  (rightSignal),
        .leftSignal   (leftSignal),
        .selectSignal (selectSignal),
        .coinPulse    (coinPulse),
        .coinValue    (coinValue),
        .itemPrice    (itemPrice),
        .cursor       (cursor),
        .credit       (credit),
        .dispense     (dispense),
        .dispenseItem (dispenseItem),
        .change       (change),
        .busy         (busy),
        .deny         (deny)
    );

    always #5 fastClk = ~fastClk;

    int n_checks = 0;
    int n_pass   = 0;
    string phase = "init";

    // Behavioural model state
    int m_credit, m_cursor, m_item, m_change, m_price, m_hold;
    bit m_check, m_is_deny, m_disp, m_prev_sel;

    typedef struct {
        logic       r;
        logic       l;
        logic [3:0] exp_cursor;
    } cur_vec_t;

    cur_vec_t vecs[12];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s/%s: got %0d expected %0d", phase, name, act, exp);
    endtask

    task automatic model_reset();
        m_credit = 0; m_cursor = 0; m_item = 0; m_change = 0; m_price = 0;
        m_hold = 0; m_check = 0; m_is_deny = 0; m_disp = 0; m_prev_sel = 0;
    endtask

    // One clock of the purchase rules, in terms of remaining hold cycles
    task automatic model_step(input bit r, input bit l, input bit s, input bit cp,
                              input int cv, input int pr);
        int base = m_credit;
        int sum;
        int cur0 = m_cursor;
        m_disp = 0;
        if (m_hold > 0) begin
            m_hold--;
        end else if (m_check) begin
            m_check = 0;
            m_hold  = HOLD;
            if (m_credit >= m_price) begin
                m_disp    = 1;
                m_is_deny = 0;
                m_change  = m_credit - m_price;
                base      = 0;
            end else begin
                m_is_deny = 1;
            end
        end else begin
            if (r && !l) m_cursor = WRAP ? (cur0 + 1) % N : ((cur0 + 1 > N - 1) ? N - 1 : cur0 + 1);
            if (l && !r) m_cursor = WRAP ? (cur0 + N - 1) % N : ((cur0 == 0) ? 0 : cur0 - 1);
            if (s && !m_prev_sel) begin
                m_item  = cur0;
                m_price = pr;
                m_check = 1;
            end
        end
        sum      = base + (cp ? cv : 0);
        m_credit = (sum > MAXC) ? MAXC : sum;
        m_prev_sel = s;
    endtask

    task automatic compare_model();
        chk("cursor",   int'(cursor),       m_cursor);
        chk("credit",   int'(credit),       m_credit);
        chk("dispense", int'(dispense),     int'(m_disp));
        chk("item",     int'(dispenseItem), m_item);
        chk("change",   int'(change),       m_change);
        chk("busy",     int'(busy),         int'(m_check || m_hold > 0));
        chk("deny",     int'(deny),         int'(m_hold > 0 && m_is_deny));
    endtask

    task automatic tick(input logic r, input logic l, input logic s, input logic cp,
                        input logic [7:0] cv, input logic [7:0] pr);
        rightSignal = r; leftSignal = l; selectSignal = s; coinPulse = cp;
        coinValue = cv; itemPrice = pr;
        @(posedge fastClk);
        model_step(r, l, s, cp, int'(cv), int'(pr));
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        rstN = 1'b0;
        rightSignal = 0; leftSignal = 0; selectSignal = 0; coinPulse = 0;
        coinValue = 0; itemPrice = 0;
        model_reset();
        repeat (2) @(posedge fastClk);
        #1;
        compare_model();
        @(negedge fastClk);
        rstN = 1'b1;
    endtask

    initial begin
        int disp_cnt, deny_cnt;
        bit s_lvl;

        // Cursor table: R x3, L, R+L, R to the top, then past both bounds
        vecs[0]  = '{1'b1, 1'b0, 4'd1};
        vecs[1]  = '{1'b1, 1'b0, 4'd2};
        vecs[2]  = '{1'b1, 1'b0, 4'd3};
        vecs[3]  = '{1'b0, 1'b1, 4'd2};
        vecs[4]  = '{1'b1, 1'b1, 4'd2};
        vecs[5]  = '{1'b1, 1'b0, 4'd3};
        vecs[6]  = '{1'b1, 1'b0, 4'd4};
        vecs[7]  = '{1'b1, 1'b0, 4'd5};
        vecs[8]  = '{1'b1, 1'b0, 4'd6};
        vecs[9]  = '{1'b1, 1'b0, 4'd7};
        vecs[10] = '{1'b1, 1'b0, WRAP ? 4'd0 : 4'd7};
        vecs[11] = '{1'b0, 1'b1, WRAP ? 4'd7 : 4'd6};

        phase = "reset";
        do_reset();
        chk("rst_cursor", int'(cursor), 0);
        chk("rst_busy",   int'(busy),   0);

        phase = "cursor_table";
        for (int i = 0; i < 12; i++) begin
            tick(vecs[i].r, vecs[i].l, 1'b0, 1'b0, 8'd0, 8'd0);
            chk($sformatf("vec%0d", i), int'(cursor), int'(vecs[i].exp_cursor));
        end

        phase = "lower_bound";
        do_reset();
        tick(1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0);
        chk("left_at_0", int'(cursor), WRAP ? 7 : 0);

        // Purchase: 25+25+10 credit, price 50, item 3
        phase = "purchase";
        do_reset();
        repeat (3) tick(1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd50);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'd25, 8'd50);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'd25, 8'd50);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'd10, 8'd50);
        chk("credit60", int'(credit), 60);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd50);
        chk("check_busy", int'(busy), 1);
        chk("check_nodisp", int'(dispense), 0);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd50);
        chk("disp_pulse", int'(dispense), 1);
        chk("disp_change", int'(change), 10);
        chk("disp_credit", int'(credit), 0);
        chk("disp_item", int'(dispenseItem), 3);
        disp_cnt = 0;
        for (int i = 0; i < HOLD - 1; i++) begin
            tick(1'b1, 1'b0, 1'b1, 1'b0, 8'd0, 8'd50);
            if (dispense) disp_cnt++;
        end
        chk("hold_busy_last", int'(busy), 1);
        chk("hold_no_repulse", disp_cnt, 0);
        chk("cursor_frozen", int'(cursor), 3);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd50);
        chk("hold_done_idle", int'(busy), 0);
        tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd50);

        // Deny: credit 30 < 50, with a select edge inside DENY
        phase = "deny";
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'd30, 8'd50);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd50);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd50);
        deny_cnt = deny ? 1 : 0;
        disp_cnt = dispense ? 1 : 0;
        for (int i = 0; i < HOLD - 1; i++) begin
            s_lvl = (i == 5) ? 1'b0 : 1'b1;
            tick(1'b0, 1'b0, s_lvl, 1'b0, 8'd0, 8'd50);
            if (deny) deny_cnt++;
            if (dispense) disp_cnt++;
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd50);
        if (deny) deny_cnt++;
        chk("deny_cycles", deny_cnt, HOLD);
        chk("deny_no_disp", disp_cnt, 0);
        chk("deny_credit", int'(credit), 30);
        repeat (3) tick(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd50);
        chk("edge_discarded", int'(busy), 0);

        // Saturation
        phase = "saturate";
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'd200, 8'd0);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'd50, 8'd0);
        chk("credit250", int'(credit), 250);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'd10, 8'd0);
        chk("credit_sat", int'(credit), 255);
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'd255, 8'd0);
        chk("credit_sat2", int'(credit), 255);

        // Reset in the 5th DISPENSE cycle; coin on entry lands after the clear
        phase = "reset_mid";
        do_reset();
        tick(1'b0, 1'b0, 1'b0, 1'b1, 8'd60, 8'd50);
        tick(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd50);
        tick(1'b0, 1'b0, 1'b1, 1'b1, 8'd7, 8'd50);
        chk("entry_coin_credit", int'(credit), 7);
        chk("entry_change", int'(change), 10);
        repeat (4) tick(1'b0, 1'b0, 1'b1, 1'b0, 8'd0, 8'd50);
        #2;
        rstN = 1'b0;
        model_reset();
        #1;
        chk("async_all_zero",
            int'({cursor, credit, dispense, dispenseItem, change, busy, deny} != '0), 0);
        @(negedge fastClk);
        rstN = 1'b1;
        disp_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 8'd50);
            if (dispense) disp_cnt++;
        end
        chk("post_reset_idle", int'(busy), 0);
        chk("post_reset_nodisp", disp_cnt, 0);

        // Random stimulus against the model
        phase = "random";
        do_reset();
        s_lvl = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (($urandom % 6) == 0) s_lvl = ~s_lvl;
            tick(1'(($urandom % 3) == 0), 1'(($urandom % 3) == 0), s_lvl,
                 1'(($urandom % 4) == 0), 8'($urandom % 96), 8'($urandom % 160));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
